da_ctrl: RTL
============

Name: da_ctrl

Overview:
Sequencer for the distributed-arithmetic FIR datapath `da`. It has three jobs:
- Streams the 8x256 precomputed ROM table from a host write port into `da` (CADDR/CIN/CLOAD).
- Accepts packed 8-lane input samples with valid/ready and issues start/reset pulses per iteration.
- Waits for `done`, accumulates FRAME_LEN iterations per frame, and presents ACC_OUT as a result with valid/ready.

Sits between the host/sample source and the `da` instance.

Parameters:
ADDR_W, 11, ROM address width ({rom_sel[2:0], index[7:0]})
COEF_W, 19, ROM word width
A_W, 8, width of each input lane A0..A7
ACC_W, 38, accumulator/result width
FRAME_LEN, 16, da iterations per result frame
TIMEOUT, 32, max cycles to wait for da_done

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
clear  in  1  synchronous abort/flush, active high
cfg_valid  in  1  ROM write request
cfg_ready  out  1  ROM write accepted when cfg_valid&cfg_ready
cfg_addr  in  ADDR_W  ROM address
cfg_data  in  COEF_W  ROM word (signed)
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid&s_ready
s_data  in  8*A_W  {A7,...,A0}
r_valid  out  1  result valid
r_ready  in  1  result consumed when r_valid&r_ready
r_data  out  ACC_W  signed frame result
da_caddr  out  ADDR_W  to da CADDR
da_cin  out  COEF_W  to da CIN
da_cload  out  1  to da CLOAD
da_a  out  8*A_W  to da A7..A0
da_start  out  1  to da start
da_reset  out  1  to da reset (accumulator clear)
da_done  in  1  from da done
da_acc_out  in  ACC_W  from da ACC_OUT
rom_ok  out  1  full table loaded
busy  out  1  state != IDLE or iter_cnt != 0
err  out  1  sticky timeout flag

Behaviour:
- Reset (resetn=0, async): state=IDLE, iter_cnt=0, wait_cnt=0, wr_cnt=0. All outputs are 0 (cfg_ready, s_ready, r_valid, da_*, rom_ok, busy, err, r_data).
- States: IDLE, RUN_WAIT, OUT. All da_* outputs are registered.
- cfg_ready = (state==IDLE) & (iter_cnt==0) & ~clear.
- ROM load:
  - Write accepted at edge T -> da_caddr=cfg_addr, da_cin=cfg_data, da_cload=1 during cycle T+1. da_cload is a one-cycle pulse per write.
  - Back-to-back writes are sustained at 1 per cycle. da_caddr/da_cin hold their last value when idle.
- wr_cnt (12 bit) increments per accepted write and saturates at 2048. rom_ok=1 when wr_cnt==2048. Rewrites after that are allowed and rom_ok stays 1.
- s_ready = (state==IDLE) & rom_ok & ~clear & ~(cfg_valid & iter_cnt==0). Config has priority over a sample at a frame boundary.
- Sample accepted at T:
  - During T+1: da_a=s_data, da_start=1 (one cycle), and da_reset=1 iff iter_cnt==0.
  - state -> RUN_WAIT, wait_cnt=0.
  - da_a is held stable until the next accepted sample.
- RUN_WAIT:
  - da_done is ignored in the cycle da_start is high.
  - On da_done=1 with iter_cnt<FRAME_LEN-1: iter_cnt++, state -> IDLE.
  - On da_done=1 with iter_cnt==FRAME_LEN-1: r_data<=da_acc_out, r_valid<=1, iter_cnt<=0, state -> OUT.
  - Otherwise wait_cnt++. If wait_cnt reaches TIMEOUT-1 without done: err<=1, iter_cnt<=0, state -> IDLE, and no result is produced.
- OUT: r_valid and r_data are held until r_ready=1, then r_valid<=0 and state -> IDLE the next cycle. s_ready=0 while in OUT (single result buffer).
- clear=1 has highest priority over all synchronous events:
  - state=IDLE, iter_cnt=0, wait_cnt=0, r_valid=0, err=0; da_start/da_cload/da_reset=0 next cycle.
  - wr_cnt and rom_ok are unchanged; ROM contents persist.
- err is sticky; only resetn or clear clears it. Sample accepts continue after err.
- resetn asserted mid-frame or mid-load aborts immediately. rom_ok drops, and the host must reload.

Decomposition:
- Package da_pkg holds:
  - ADDR_W, COEF_W, A_W, ACC_W, FRAME_LEN, TIMEOUT defaults;
  - ROM_DEPTH=2048;
  - state enum {IDLE, RUN_WAIT, OUT}.
- One sub-module, da_rom_loader, is natural: the cfg handshake, the registered CADDR/CIN/CLOAD outputs, and wr_cnt/rom_ok.
- Sample sequencing and the frame FSM remain in da_ctrl.

Test Plan:
- Reset then load: 2048 back-to-back writes, addr 0..2047, data = addr-262144.
  - Required: da_cload pulses 2048 cycles, each da_caddr/da_cin one cycle after its accept.
  - Required: rom_ok rises the cycle after the 2048th accept; s_ready stays 0 before that.
- One frame with a da model (done 11 cycles after start, ACC_OUT=16'h1234 at frame end):
  - Drive 16 samples.
  - Required: da_reset=1 only with the first da_start.
  - Required: r_valid=1 with r_data=0x1234 after the 16th done; s_ready=0 until r_ready.
- Backpressure: hold r_ready=0 for 20 cycles with s_valid=1.
  - Required: r_data stable, no da_start issued.
  - Required: after r_ready, the next sample produces da_start with da_reset=1.
- Timeout: the da model never asserts done.
  - Required: err=1 exactly TIMEOUT cycles after da_start, state IDLE, no r_valid.
  - Required: the next frame starts with da_reset=1.
- Priority: in IDLE with iter_cnt=0, drive cfg_valid and s_valid together.
  - Required: the cfg write is accepted and s_ready=0 that cycle.
  - Required: with iter_cnt=5, cfg_ready=0.
- Clear mid-frame after 7 iterations.
  - Required: iter_cnt=0, err=0, rom_ok stays 1.
  - Required: the next sample issues da_reset=1; 16 further samples yield one result.

Source files
------------

// File: rtl/da_pkg.sv
// da_pkg: shared constants and types for the DA FIR sequencer.
// Defaults here feed the parameters of da_ctrl and da_rom_loader.
package da_pkg;

    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_COEF_W    = 19;
    localparam int DEF_A_W       = 8;
    localparam int DEF_ACC_W     = 38;
    localparam int DEF_FRAME_LEN = 16;
    localparam int DEF_TIMEOUT   = 32;

    localparam int ROM_DEPTH = 2048;
    localparam int WR_CNT_W  = $clog2(ROM_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_WAIT = 2'd1,
        OUT      = 2'd2
    } state_t;

    // Write counter step that parks at a full table.
    function automatic logic [WR_CNT_W-1:0] wr_cnt_next(
        input logic [WR_CNT_W-1:0] cnt
    );
        if (cnt == WR_CNT_W'(ROM_DEPTH)) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/da_rom_loader.sv
// da_rom_loader: host ROM write port feeding the da coefficient table.
// Registers CADDR/CIN/CLOAD and tracks when the full table is written.
module da_rom_loader
    import da_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_en,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [COEF_W-1:0] i_cfg_data,
    output logic [ADDR_W-1:0] o_caddr,
    output logic [COEF_W-1:0] o_cin,
    output logic              o_cload,
    output logic              o_rom_ok
);

    logic [ADDR_W-1:0]   r_caddr;
    logic [COEF_W-1:0]   r_cin;
    logic                r_cload;
    logic [WR_CNT_W-1:0] r_wr_cnt;
    logic                w_acc;

    assign o_cfg_ready = i_en;
    assign w_acc       = i_cfg_valid & i_en;

    // One CLOAD pulse per accepted write; address/data hold between writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_caddr  <= '0;
            r_cin    <= '0;
            r_cload  <= 1'b0;
            r_wr_cnt <= '0;
        end else begin
            r_cload <= w_acc;
            if (w_acc) begin
                r_caddr  <= i_cfg_addr;
                r_cin    <= i_cfg_data;
                r_wr_cnt <= wr_cnt_next(r_wr_cnt);
            end
        end
    end

    assign o_caddr  = r_caddr;
    assign o_cin    = r_cin;
    assign o_cload  = r_cload;
    assign o_rom_ok = (r_wr_cnt == WR_CNT_W'(ROM_DEPTH));

endmodule

// File: rtl/da_ctrl.sv
// da_ctrl: sequencer for the distributed-arithmetic FIR datapath.
// Loads the ROM, issues per-sample start pulses and frames results.
module da_ctrl
    import da_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int A_W       = DEF_A_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [COEF_W-1:0]  cfg_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*A_W-1:0]   s_data,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [ACC_W-1:0]   r_data,
    output logic [ADDR_W-1:0]  da_caddr,
    output logic [COEF_W-1:0]  da_cin,
    output logic               da_cload,
    output logic [8*A_W-1:0]   da_a,
    output logic               da_start,
    output logic               da_reset,
    input  logic               da_done,
    input  logic [ACC_W-1:0]   da_acc_out,
    output logic               rom_ok,
    output logic               busy,
    output logic               err
);

    localparam int ITER_W = $clog2(FRAME_LEN);
    localparam int WAIT_W = $clog2(TIMEOUT);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(FRAME_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [ITER_W-1:0]  r_iter_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_res_valid;
    logic [ACC_W-1:0]   r_res_data;
    logic [8*A_W-1:0]   r_da_a;
    logic               r_da_start;
    logic               r_da_reset;
    logic               r_err;

    logic w_idle;
    logic w_frame_first;
    logic w_cfg_en;
    logic w_rom_ok;
    logic w_s_acc;
    logic w_done;
    logic w_last_iter;
    logic w_wait_over;

    assign w_idle        = (r_state == IDLE);
    assign w_frame_first = (r_iter_cnt == '0);

    // Config only between frames; resetn gate keeps ready low in reset.
    assign w_cfg_en = resetn & w_idle & w_frame_first & ~clear;

    // A config request at a frame boundary wins over a sample.
    assign s_ready = w_idle & w_rom_ok & ~clear
                   & ~(cfg_valid & w_frame_first);

    assign w_s_acc = s_valid & s_ready;

    // done in the start cycle belongs to a previous run; ignore it.
    assign w_done      = da_done & ~r_da_start;
    assign w_last_iter = (r_iter_cnt == ITER_LAST);
    assign w_wait_over = (r_wait_cnt == WAIT_LAST);

    da_rom_loader #(
        .ADDR_W (ADDR_W),
        .COEF_W (COEF_W)
    ) u_loader (
        .clk         (clk),
        .resetn      (resetn),
        .i_en        (w_cfg_en),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_data  (cfg_data),
        .o_caddr     (da_caddr),
        .o_cin       (da_cin),
        .o_cload     (da_cload),
        .o_rom_ok    (w_rom_ok)
    );

    // Frame FSM: issue a start, wait for done or timeout, hold result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_iter_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_da_a      <= '0;
            r_da_start  <= 1'b0;
            r_da_reset  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_da_start <= 1'b0;
            r_da_reset <= 1'b0;
            if (clear) begin
                r_state     <= IDLE;
                r_iter_cnt  <= '0;
                r_wait_cnt  <= '0;
                r_res_valid <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_s_acc) begin
                            r_da_a     <= s_data;
                            r_da_start <= 1'b1;
                            r_da_reset <= w_frame_first;
                            r_wait_cnt <= '0;
                            r_state    <= RUN_WAIT;
                        end
                    end
                    RUN_WAIT: begin
                        if (w_done) begin
                            if (w_last_iter) begin
                                r_res_data  <= da_acc_out;
                                r_res_valid <= 1'b1;
                                r_iter_cnt  <= '0;
                                r_state     <= OUT;
                            end else begin
                                r_iter_cnt <= r_iter_cnt + 1'b1;
                                r_state    <= IDLE;
                            end
                        end else if (w_wait_over) begin
                            r_err      <= 1'b1;
                            r_iter_cnt <= '0;
                            r_state    <= IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    OUT: begin
                        if (r_ready) begin
                            r_res_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign r_valid  = r_res_valid;
    assign r_data   = r_res_data;
    assign da_a     = r_da_a;
    assign da_start = r_da_start;
    assign da_reset = r_da_reset;
    assign rom_ok   = w_rom_ok;
    assign busy     = ~w_idle | ~w_frame_first;
    assign err      = r_err;

endmodule
